// File: rtl/addsub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : addsub_pkg                                             |
// | Description : Shared mode encoding and result-flag bundle for the    |
// |               pipelined adder/subtractor.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package addsub_pkg;

   // Mode encoding presented on the M input.
   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

   // Status flags that travel with every result.
   typedef struct packed {
      logic cout;   // carry out; in subtract mode 1 = no borrow
      logic ovf;    // signed overflow of the unsaturated result
      logic zero;   // final S == 0
      logic neg;    // final S MSB
   } flags_t;

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/addsub_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : addsub_pipe_if                                         |
// | Description : Operand/result handshake bundle of addsub_pipe.        |
// |   in_valid/in_ready : operand-side handshake                         |
// |   A, B, M, SAT      : operands, mode (0 add, 1 sub), saturate enable |
// |   out_valid/out_ready : result-side handshake                        |
// |   S, Cout, OVF, ZERO, NEG : result and flags                         |
// |   master : producer/consumer side, slave : the pipeline              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface addsub_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             M;
   logic             SAT;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] S;
   logic             Cout;
   logic             OVF;
   logic             ZERO;
   logic             NEG;

   modport master (
      output in_valid, A, B, M, SAT, out_ready,
      input  in_ready, out_valid, S, Cout, OVF, ZERO, NEG
   );

   modport slave (
      input  in_valid, A, B, M, SAT, out_ready,
      output in_ready, out_valid, S, Cout, OVF, ZERO, NEG
   );
endinterface : addsub_pipe_if
`default_nettype wire

// File: rtl/addsub_seg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : addsub_seg                                             |
// | Description : One combinational carry segment of the adder chain.   |
// |   a, b      : segment operand slices (b is inverted when m = 1)      |
// |   m         : mode, 0 add / 1 subtract                               |
// |   cin       : carry into the segment                                 |
// |   sum       : segment result slice                                   |
// |   cout      : carry out of the segment                               |
// |   msb_carry : carry into the segment's top bit                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module addsub_seg #(
   parameter int SEG_W = 8
) (
   input  logic [SEG_W-1:0] a,
   input  logic [SEG_W-1:0] b,
   input  logic             m,
   input  logic             cin,
   output logic [SEG_W-1:0] sum,
   output logic             cout,
   output logic             msb_carry
);
   logic [SEG_W-1:0] w_beff;
   logic [SEG_W:0]   w_full;

   assign w_beff = b ^ {SEG_W{m}};
   assign w_full = {1'b0, a} + {1'b0, w_beff} + {{SEG_W{1'b0}}, cin};
   assign sum    = w_full[SEG_W-1:0];
   assign cout   = w_full[SEG_W];
   // Top sum bit is a ^ b ^ carry-in, so the carry into it falls out directly.
   assign msb_carry = w_full[SEG_W-1] ^ a[SEG_W-1] ^ w_beff[SEG_W-1];
endmodule : addsub_seg
`default_nettype wire

// File: rtl/addsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : addsub_pipe                                            |
// | Description : WIDTH-bit add/subtract with optional signed saturation,|
// |               carry chain split into STAGES segments, one pipeline   |
// |               register per segment, valid/ready flow control.        |
// |   clk  : clock, all state on rising edge                             |
// |   rst  : synchronous active-high reset                               |
// |   bus  : addsub_pipe_if.slave (operand and result handshakes)        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input logic          clk,
   input logic          rst,
   addsub_pipe_if.slave bus
);
   localparam int SEG_W = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;
   localparam int NPIPE = (STAGES > 1) ? STAGES - 1 : 1;

   localparam logic [WIDTH-1:0] c_MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] c_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   // Stage valids; the last one is out_valid.
   logic             r_v   [STAGES];
   // Intermediate stage contents: operands still to be consumed plus the
   // partial sum and carry resolved so far.
   logic [WIDTH-1:0] r_a   [NPIPE];
   logic [WIDTH-1:0] r_b   [NPIPE];
   logic [WIDTH-1:0] r_sum [NPIPE];
   logic             r_m   [NPIPE];
   logic             r_sat [NPIPE];
   logic             r_c   [NPIPE];
   // Output stage.
   logic [WIDTH-1:0] r_s;
   flags_t           r_flags;

   logic [STAGES-1:0]            w_rdy;
   logic [STAGES-1:0]            w_vin;
   logic [STAGES-1:0]            w_m;
   logic [STAGES-1:0]            w_sat;
   logic [STAGES-1:0]            w_cin;
   logic [STAGES-1:0]            w_cout;
   logic [STAGES-1:0][SEG_W-1:0] w_a_seg;
   logic [STAGES-1:0][SEG_W-1:0] w_b_seg;
   logic [STAGES-1:0][SEG_W-1:0] w_seg_sum;
   logic [STAGES-1:0][WIDTH-1:0] w_sum_new;
   logic [NPIPE-1:0][WIDTH-1:0]  w_a_full;
   logic [NPIPE-1:0][WIDTH-1:0]  w_b_full;
   logic                         w_mc_last;
   logic                         w_ovf;
   logic                         w_sat_hit;
   logic [WIDTH-1:0]             w_s_fin;

   // A stage may load when it is empty or its content moves on this cycle;
   // evaluated from the output back so a draining tail frees the whole pipe.
   always_comb begin
      w_rdy       = '0;
      w_rdy[LAST] = !r_v[LAST] || bus.out_ready;
      for (int k = LAST - 1; k >= 0; k--) begin
         w_rdy[k] = !r_v[k] || w_rdy[k+1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] w_prev;
      logic [WIDTH-1:0] w_merge;
      logic             w_msb_c;

      if (k == 0) begin : g_first
         assign w_vin[k]   = bus.in_valid;
         assign w_a_seg[k] = bus.A[k*SEG_W +: SEG_W];
         assign w_b_seg[k] = bus.B[k*SEG_W +: SEG_W];
         assign w_m[k]     = bus.M;
         assign w_sat[k]   = bus.SAT;
         assign w_cin[k]   = bus.M;    // the +1 of two's-complement negation
         assign w_prev     = '0;
         if (LAST > 0) begin : g_fwd
            assign w_a_full[k] = bus.A;
            assign w_b_full[k] = bus.B;
         end
      end else begin : g_next
         assign w_vin[k]   = r_v[k-1];
         assign w_a_seg[k] = r_a[k-1][k*SEG_W +: SEG_W];
         assign w_b_seg[k] = r_b[k-1][k*SEG_W +: SEG_W];
         assign w_m[k]     = r_m[k-1];
         assign w_sat[k]   = r_sat[k-1];
         assign w_cin[k]   = r_c[k-1];
         assign w_prev     = r_sum[k-1];
         if (k < LAST) begin : g_fwd
            assign w_a_full[k] = r_a[k-1];
            assign w_b_full[k] = r_b[k-1];
         end
      end

      addsub_seg #(
         .SEG_W (SEG_W)
      ) u_seg (
         .a         (w_a_seg[k]),
         .b         (w_b_seg[k]),
         .m         (w_m[k]),
         .cin       (w_cin[k]),
         .sum       (w_seg_sum[k]),
         .cout      (w_cout[k]),
         .msb_carry (w_msb_c)
      );

      always_comb begin
         w_merge                    = w_prev;
         w_merge[k*SEG_W +: SEG_W]  = w_seg_sum[k];
      end
      assign w_sum_new[k] = w_merge;

      if (k == LAST) begin : g_tail
         assign w_mc_last = w_msb_c;
      end else begin : g_mid
         logic w_unused_mc;
         assign w_unused_mc = w_msb_c;
      end
   end

   // Overflow: carry into the MSB differs from carry out of it. Saturation
   // direction follows the sign of A (both operands share it on overflow).
   assign w_ovf     = w_cout[LAST] ^ w_mc_last;
   assign w_sat_hit = w_sat[LAST] && w_ovf;
   assign w_s_fin   = w_sat_hit ? (w_a_seg[LAST][SEG_W-1] ? c_MIN_NEG : c_MAX_POS)
                                : w_sum_new[LAST];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            r_v[k] <= 1'b0;
         end
         for (int k = 0; k < NPIPE; k++) begin
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_sum[k] <= '0;
            r_m[k]   <= 1'b0;
            r_sat[k] <= 1'b0;
            r_c[k]   <= 1'b0;
         end
         r_s     <= '0;
         r_flags <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (w_rdy[k]) begin
               r_v[k] <= w_vin[k];
            end
         end
         // Data only moves with a valid token so a stalled or empty stage
         // keeps its outputs steady.
         for (int k = 0; k < LAST; k++) begin
            if (w_rdy[k] && w_vin[k]) begin
               r_a[k]   <= w_a_full[k];
               r_b[k]   <= w_b_full[k];
               r_m[k]   <= w_m[k];
               r_sat[k] <= w_sat[k];
               r_c[k]   <= w_cout[k];
               r_sum[k] <= w_sum_new[k];
            end
         end
         if (w_rdy[LAST] && w_vin[LAST]) begin
            r_s     <= w_s_fin;
            r_flags <= '{cout: w_cout[LAST],
                         ovf:  w_ovf,
                         zero: (w_s_fin == '0),
                         neg:  w_s_fin[WIDTH-1]};
         end
      end
   end

   assign bus.in_ready  = w_rdy[0] && !rst;
   assign bus.out_valid = r_v[LAST];
   assign bus.S         = r_s;
   assign bus.Cout      = r_flags.cout;
   assign bus.OVF       = r_flags.ovf;
   assign bus.ZERO      = r_flags.zero;
   assign bus.NEG       = r_flags.neg;

endmodule : addsub_pipe
`default_nettype wire

// File: tb/tb_addsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_addsub_pipe                                         |
// | Description : Self-checking bench for addsub_pipe (WIDTH 16,         |
// |               STAGES 2) with an arithmetic reference model.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_addsub_pipe;
   import addsub_pkg::*;

   typedef struct packed {
      logic [15:0] s;
      logic        c;
      logic        o;
      logic        z;
      logic        n;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   addsub_pipe_if #(.WIDTH(16)) bus ();

   addsub_pipe #(
      .WIDTH  (16),
      .STAGES (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference: plain (WIDTH+1)-bit arithmetic and the textual flag rules.
   function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic m, input logic sat);
      logic [15:0] beff;
      logic [31:0] full;
      logic [15:0] raw;
      res_t        r;
      beff = m ? ~b : b;
      full = 32'(a) + 32'(beff) + 32'(m);
      raw  = full[15:0];
      r.c  = full[16];
      r.o  = (a[15] == beff[15]) && (raw[15] != a[15]);
      r.s  = (sat && r.o) ? (a[15] ? 16'h8000 : 16'h7FFF) : raw;
      r.z  = (r.s == 16'h0000);
      r.n  = r.s[15];
      return r;
   endfunction

   function automatic res_t sample();
      res_t r;
      r.s = bus.S;
      r.c = bus.Cout;
      r.o = bus.OVF;
      r.z = bus.ZERO;
      r.n = bus.NEG;
      return r;
   endfunction

   // Issues one op on an empty pipe and reports latency (-1 = never seen).
   task automatic single_op(input logic [15:0] a, input logic [15:0] b,
                            input logic m, input logic sat,
                            output int lat, output res_t got);
      lat = -1;
      got = '0;
      bus.A = a; bus.B = b; bus.M = m; bus.SAT = sat;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(negedge clk);
      if (!bus.in_ready) begin
         @(posedge clk); #1 bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1 bus.in_valid = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            lat = n;
            got = sample();
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b1; bus.A = 16'h1111; bus.B = 16'h2222;
      bus.M = ADD; bus.SAT = 1'b0; bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready);
      end
      checks++;
      if ({bus.out_valid, bus.S, bus.Cout, bus.OVF, bus.ZERO, bus.NEG} !== 21'h0) begin
         errors++;
         $display("FAIL rst_outputs: got v=%b S=%h flags=%b%b%b%b expected all 0",
                  bus.out_valid, bus.S, bus.Cout, bus.OVF, bus.ZERO, bus.NEG);
      end
      @(posedge clk); #1 rst = 1'b0; bus.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL rst_release_ready: got %b expected 1", bus.in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_no_accept: got out_valid %b expected 0", bus.out_valid);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_carry_boundary();
      int   lat;
      res_t got;
      single_op(16'h00FF, 16'h0001, ADD, 1'b0, lat, got);
      checks++;
      if (lat !== 2) begin
         errors++; $display("FAIL carry_latency: got %0d expected 2", lat);
      end
      checks++;
      if ({got.s, got.c, got.o, got.z} !== {16'h0100, 3'b000}) begin
         errors++; $display("FAIL carry_result: got S=%h C=%b O=%b Z=%b expected S=0100 C=0 O=0 Z=0",
                            got.s, got.c, got.o, got.z);
      end
   endtask

   task automatic test_subtract();
      int   lat;
      res_t got;
      single_op(16'h0005, 16'h0007, SUB, 1'b0, lat, got);
      checks++;
      if (lat !== 2 || {got.s, got.c, got.n} !== {16'hFFFE, 1'b0, 1'b1}) begin
         errors++; $display("FAIL sub_neg: lat=%0d S=%h C=%b N=%b expected lat=2 S=FFFE C=0 N=1",
                            lat, got.s, got.c, got.n);
      end
      single_op(16'h1234, 16'h1234, SUB, 1'b0, lat, got);
      checks++;
      if (lat !== 2 || {got.s, got.c, got.z} !== {16'h0000, 1'b1, 1'b1}) begin
         errors++; $display("FAIL sub_zero: lat=%0d S=%h C=%b Z=%b expected lat=2 S=0000 C=1 Z=1",
                            lat, got.s, got.c, got.z);
      end
   endtask

   task automatic test_saturation();
      int   lat;
      res_t got;
      single_op(16'h7FFF, 16'h0001, ADD, 1'b0, lat, got);
      checks++;
      if (lat !== 2 || {got.s, got.o} !== {16'h8000, 1'b1}) begin
         errors++; $display("FAIL ovf_wrap: lat=%0d S=%h O=%b expected lat=2 S=8000 O=1", lat, got.s, got.o);
      end
      single_op(16'h7FFF, 16'h0001, ADD, 1'b1, lat, got);
      checks++;
      if (lat !== 2 || {got.s, got.o, got.n} !== {16'h7FFF, 1'b1, 1'b0}) begin
         errors++; $display("FAIL sat_pos: lat=%0d S=%h O=%b N=%b expected lat=2 S=7FFF O=1 N=0",
                            lat, got.s, got.o, got.n);
      end
      single_op(16'h8000, 16'h0001, SUB, 1'b1, lat, got);
      checks++;
      if (lat !== 2 || {got.s, got.o, got.n} !== {16'h8000, 1'b1, 1'b1}) begin
         errors++; $display("FAIL sat_neg: lat=%0d S=%h O=%b N=%b expected lat=2 S=8000 O=1 N=1",
                            lat, got.s, got.o, got.n);
      end
   endtask

   task automatic test_random();
      res_t q[$];
      res_t cur, prev, exp;
      logic prev_stall = 1'b0;
      int   issued = 0;
      prev = '0;
      for (int cyc = 0; cyc < 1000 && (issued < 150 || q.size() > 0); cyc++) begin
         bus.in_valid  = (issued < 150) && ($urandom_range(0, 3) != 0);
         bus.A         = 16'($urandom);
         bus.B         = 16'($urandom);
         bus.M         = 1'($urandom_range(0, 1));
         bus.SAT       = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         cur = sample();
         if (prev_stall) begin
            checks++;
            if (bus.out_valid !== 1'b1 || cur !== prev) begin
               errors++; $display("FAIL rnd_hold: got v=%b %h expected v=1 %h", bus.out_valid, cur, prev);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL rnd_extra: got result %h expected none", cur);
            end else begin
               exp = q.pop_front();
               if (cur !== exp) begin
                  errors++; $display("FAIL rnd_result: got %h expected %h", cur, exp);
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(model(bus.A, bus.B, bus.M, bus.SAT));
            issued++;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev       = cur;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (q.size() != 0 || issued != 150) begin
         errors++; $display("FAIL rnd_drain: got issued=%0d pending=%0d expected 150 and 0", issued, q.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] oa [6];
      logic [15:0] ob [6];
      logic        om [6];
      logic        os [6];
      res_t        q[$];
      res_t        cur, held, exp;
      int          nissue = 0;
      int          nres = 0;
      held = '0;
      for (int i = 0; i < 6; i++) begin
         oa[i] = 16'($urandom); ob[i] = 16'($urandom);
         om[i] = 1'($urandom_range(0, 1)); os[i] = 1'($urandom_range(0, 1));
      end
      for (int cyc = 0; cyc < 40 && nres < 6; cyc++) begin
         bus.in_valid = (nissue < 6);
         if (nissue < 6) begin
            bus.A = oa[nissue]; bus.B = ob[nissue]; bus.M = om[nissue]; bus.SAT = os[nissue];
         end
         bus.out_ready = !(cyc >= 3 && cyc <= 5);
         @(negedge clk);
         cur = sample();
         if (cyc == 3) begin
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
               errors++; $display("FAIL b2b_full: got in_ready=%b out_valid=%b expected 0 1",
                                  bus.in_ready, bus.out_valid);
            end
            held = cur;
         end
         if (cyc == 4 || cyc == 5) begin
            checks++;
            if (bus.out_valid !== 1'b1 || cur !== held || bus.in_ready !== 1'b0) begin
               errors++; $display("FAIL b2b_hold: got v=%b rdy=%b %h expected v=1 rdy=0 %h",
                                  bus.out_valid, bus.in_ready, cur, held);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL b2b_extra: got result %h expected none", cur);
            end else begin
               exp = q.pop_front();
               if (cur !== exp) begin
                  errors++; $display("FAIL b2b_result: got %h expected %h", cur, exp);
               end
            end
            nres++;
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(model(bus.A, bus.B, bus.M, bus.SAT));
            nissue++;
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (nres != 6 || nissue != 6) begin
         errors++; $display("FAIL b2b_count: got issued=%0d results=%0d expected 6 6", nissue, nres);
      end
   endtask

   task automatic test_reset_flight();
      int   nacc = 0;
      int   seen = 0;
      int   lat;
      res_t got;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.A = 16'($urandom); bus.B = 16'($urandom); bus.M = ADD; bus.SAT = 1'b0;
         bus.in_valid = 1'b1;
         @(negedge clk);
         if (bus.in_ready) nacc++;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (nacc != 2 || bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL flight_setup: got accepted=%0d in_ready=%b expected 2 0", nacc, bus.in_ready);
      end
      @(posedge clk); #1 rst = 1'b0; bus.out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.S !== 16'h0000 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL flight_cleared: got v=%b S=%h rdy=%b expected v=0 S=0000 rdy=1",
                            bus.out_valid, bus.S, bus.in_ready);
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL flight_discard: got %0d stale results expected 0", seen);
      end
      @(posedge clk); #1;
      single_op(16'h4000, 16'h1000, ADD, 1'b0, lat, got);
      checks++;
      if (lat !== 2 || got !== model(16'h4000, 16'h1000, ADD, 1'b0)) begin
         errors++; $display("FAIL flight_recover: got lat=%0d S=%h expected lat=2 S=5000", lat, got.s);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.M = 1'b0; bus.SAT = 1'b0;
      bus.out_ready = 1'b1;
      test_reset();
      test_carry_boundary();
      test_subtract();
      test_saturation();
      test_random();
      test_back_to_back();
      test_reset_flight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_addsub_pipe
`default_nettype wire

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits, minimum 4.
REQ-002 SHALL have parameter STAGES, default 2: number of carry segments and pipeline registers; WIDTH SHALL be divisible by STAGES.
REQ-003 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operand set A/B/M/SAT presented.
REQ-006 SHALL have port in_ready, output, 1: operand set accepted this cycle when in_valid && in_ready.
REQ-007 SHALL have port A, input, WIDTH: first operand.
REQ-008 SHALL have port B, input, WIDTH: second operand.
REQ-009 SHALL have port M, input, 1: mode, 0 = add, 1 = subtract (A - B).
REQ-010 SHALL have port SAT, input, 1: 1 = signed saturation on overflow.
REQ-011 SHALL have port out_valid, output, 1: result presented.
REQ-012 SHALL have port out_ready, input, 1: consumer takes result when out_valid && out_ready.
REQ-013 SHALL have port S, output, WIDTH: sum/difference.
REQ-014 SHALL have port Cout, output, 1: carry out; in subtract mode 1 = no borrow.
REQ-015 SHALL have port OVF, output, 1: signed overflow of the unsaturated result.
REQ-016 SHALL have port ZERO, output, 1: S == 0.
REQ-017 SHALL have port NEG, output, 1: S[WIDTH-1].

Function
REQ-018 SHALL compute {Cout, raw} = A + (B ^ {WIDTH{M}}) + M, modulo 2^(WIDTH+1).
REQ-019 SHALL split the carry chain into STAGES equal segments of WIDTH/STAGES bits, segment k resolved in pipeline stage k, carry registered between stages.
REQ-020 SHALL register A/B/M/SAT upper-segment bits alongside the partial result so each stage sees only registered inputs.
REQ-021 SHALL set OVF = (A[MSB] == Beff[MSB]) && (raw[MSB] != A[MSB]), Beff = B ^ {WIDTH{M}}.
REQ-022 SHALL, when SAT=1 and OVF=1, drive S = 0 followed by all ones (max positive) if A[MSB]=0, else 1 followed by all zeros (min negative); otherwise S = raw.
REQ-023 SHALL leave Cout and OVF unaffected by saturation; ZERO and NEG SHALL reflect final S.
REQ-024 SHALL present a result exactly STAGES cycles after acceptance when out_ready is held high.
REQ-025 SHALL sustain one accepted operation per cycle with no backpressure.
REQ-026 SHALL advance stage k when it is empty or stage k+1 advances/is drained that cycle; last stage drains on out_valid && out_ready.
REQ-027 SHALL drive in_ready = stage 0 can load, combinationally including same-cycle drain; no bubble SHALL be inserted on a full pipe with out_ready high.
REQ-028 SHALL hold S/Cout/OVF/ZERO/NEG/out_valid stable while out_valid && !out_ready.
REQ-029 SHALL deliver results in acceptance order, none dropped or duplicated; capacity is STAGES operations.
REQ-030 SHALL ignore A/B/M/SAT when in_valid is low or in_ready is low.

Reset
REQ-031 SHALL, on rst high at a clock edge, clear all stage valid bits, discarding in-flight operations, and drive out_valid=0, S=0, Cout=0, OVF=0, ZERO=0, NEG=0.
REQ-032 SHALL hold in_ready=0 while rst is high, and drive in_ready=1 on the first cycle after rst deasserts.
REQ-033 SHALL accept no operation in a cycle where rst is high, regardless of in_valid.

Structure
REQ-034 SHALL place the mode encoding constants (ADD=0, SUB=1) and a flags struct {Cout, OVF, ZERO, NEG} in shared package addsub_pkg.
REQ-035 SHALL implement one carry segment as sub-module addsub_seg (combinational, parameter SEG_W, inputs a/b/m/cin, outputs sum/cout/msb-carry), instantiated STAGES times.

Verification
REQ-036 SHALL check A=0x00FF, B=0x0001, M=0: cycle 2 gives S=0x0100, Cout=0, OVF=0, ZERO=0 (WIDTH=16, STAGES=2, carry crosses segment boundary).
REQ-037 SHALL check A=0x0005, B=0x0007, M=1: S=0xFFFE, Cout=0, NEG=1; then A=0x1234, B=0x1234, M=1: S=0x0000, Cout=1, ZERO=1.
REQ-038 SHALL check A=0x7FFF, B=0x0001, M=0, SAT=0 -> S=0x8000, OVF=1; SAT=1 -> S=0x7FFF, OVF=1; A=0x8000, B=0x0001, M=1, SAT=1 -> S=0x8000, OVF=1.
REQ-039 SHALL check a back-to-back stream of 6 ops with out_ready low for cycles 3-5: in_ready falls once 2 ops are held, outputs stay stable, all 6 results emerge in order.
REQ-040 SHALL check rst asserted one cycle while 2 ops are in flight: out_valid=0 next cycle, neither result ever emerges, and a new op issued after reset returns correctly in 2 cycles.
